// File: rtl/keypad_encoder_deb.sv
// ==========================================================================
// keypad_encoder_deb : synchronised, debounced one-hot keypad to binary
// encoder with multi-key rejection.   Revision 1.0
// ==========================================================================
`default_nettype none

module keypad_encoder_deb #(
   parameter int NUM_KEYS        = 10,
   parameter int DATA_W          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] keypad,
   input  logic                enablen,
   output logic [DATA_W-1:0]   D,
   output logic                loadn,
   output logic                pgt_1hz,
   output logic                invalid
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      PRESSED  = 3'd2,
      RELEASE  = 3'd3,
      LOCKOUT  = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_q;
   logic [NUM_KEYS-1:0]                  ks;
   logic [NUM_KEYS-1:0]                  pat;
   logic [CNT_W-1:0]                     cnt;
   logic [CNT_W-1:0]                     cnt_inc;
   logic [DATA_W-1:0]                    pat_code;
   logic                                 ks_zero;
   logic                                 ks_single;
   logic                                 ks_multi;
   state_t                               state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], keypad};
      end
   end

   assign ks = sync_q[SYNC_STAGES-1];

   // Clearing the lowest set bit leaves zero only for a single-bit pattern.
   assign ks_zero   = (ks == '0);
   assign ks_single = !ks_zero && ((ks & (ks - NUM_KEYS'(1))) == '0);
   assign ks_multi  = !ks_zero && !ks_single;

   assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CNT_ONE;

   always_comb begin
      pat_code = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (pat[i]) begin
            pat_code = DATA_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         pat     <= '0;
         D       <= '0;
         loadn   <= 1'b1;
         pgt_1hz <= 1'b0;
         invalid <= 1'b0;
      end else begin
         loadn   <= 1'b1;
         invalid <= 1'b0;
         case (state)
            IDLE: begin
               if (!enablen) begin
                  if (ks_single) begin
                     pat   <= ks;
                     cnt   <= CNT_ONE;
                     state <= DEBOUNCE;
                  end else if (ks_multi) begin
                     invalid <= 1'b1;
                     cnt     <= '0;
                     state   <= LOCKOUT;
                  end
               end
            end
            DEBOUNCE: begin
               if (!enablen && (ks == pat)) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     D       <= pat_code;
                     loadn   <= 1'b0;
                     pgt_1hz <= 1'b1;
                     state   <= PRESSED;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            PRESSED: begin
               if (ks_zero) begin
                  cnt   <= CNT_ONE;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               if (ks_zero) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     pgt_1hz <= 1'b0;
                     state   <= IDLE;
                  end
               end else begin
                  state <= PRESSED;
               end
            end
            LOCKOUT: begin
               // Any key activity restarts the quiet-period count.
               if (ks_zero) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keypad_encoder_deb.sv
// ==========================================================================
// tb_keypad_encoder_deb : directed and random checks of keypad_encoder_deb
// against a behavioural model.   Revision 1.0
// ==========================================================================
`default_nettype none

module tb_keypad_encoder_deb;

   localparam int NK   = 10;
   localparam int DW   = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   localparam int M_IDLE = 0;
   localparam int M_CAND = 1;
   localparam int M_HELD = 2;
   localparam int M_LOCK = 3;

   logic          clk;
   logic          resetn;
   logic [NK-1:0] keypad;
   logic          enablen;
   logic [DW-1:0] D;
   logic          loadn;
   logic          pgt_1hz;
   logic          invalid;

   int total = 0;
   int bad   = 0;
   int lo_cnt  = 0;
   int inv_cnt = 0;

   keypad_encoder_deb #(
      .NUM_KEYS(NK), .DATA_W(DW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .resetn(resetn), .keypad(keypad), .enablen(enablen),
      .D(D), .loadn(loadn), .pgt_1hz(pgt_1hz), .invalid(invalid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int key_of(input logic [NK-1:0] v);
      logic [NK-1:0] one;
      one = NK'(1);
      for (int i = 0; i < NK; i++) begin
         if (v == (one << i)) return i;
      end
      return -1;
   endfunction

   // Model: a delay line for ks, then modes driven by run lengths of samples.
   logic [NK-1:0] m_syn [SYNC];
   int            m_mode;
   int            m_run;
   logic [NK-1:0] m_cand;
   logic [DW-1:0] e_D;
   logic          e_loadn, e_pgt, e_inv;

   always @(posedge clk or negedge resetn) begin : model
      logic [NK-1:0] kv;
      int            nb;
      if (!resetn) begin
         for (int i = 0; i < SYNC; i++) m_syn[i] <= '0;
         m_mode  <= M_IDLE;
         m_run   <= 0;
         m_cand  <= '0;
         e_D     <= '0;
         e_loadn <= 1'b1;
         e_pgt   <= 1'b0;
         e_inv   <= 1'b0;
      end else begin
         kv = m_syn[SYNC-1];
         nb = $countones(kv);
         m_syn[0] <= keypad;
         for (int i = 1; i < SYNC; i++) m_syn[i] <= m_syn[i-1];
         e_loadn <= 1'b1;
         e_inv   <= 1'b0;
         case (m_mode)
            M_IDLE: begin
               if (!enablen && nb == 1) begin
                  m_cand <= kv;
                  m_run  <= 1;
                  m_mode <= M_CAND;
               end else if (!enablen && nb > 1) begin
                  e_inv  <= 1'b1;
                  m_run  <= 0;
                  m_mode <= M_LOCK;
               end
            end
            M_CAND: begin
               if (!enablen && kv == m_cand) begin
                  if (m_run + 1 >= DEB) begin
                     e_D     <= DW'(key_of(kv));
                     e_loadn <= 1'b0;
                     e_pgt   <= 1'b1;
                     m_run   <= 0;
                     m_mode  <= M_HELD;
                  end else begin
                     m_run <= m_run + 1;
                  end
               end else begin
                  m_mode <= M_IDLE;
               end
            end
            default: begin
               // Held key or lockout: need DEB consecutive empty samples.
               if (nb == 0) begin
                  if (m_run + 1 >= DEB) begin
                     e_pgt  <= 1'b0;
                     m_mode <= M_IDLE;
                  end else begin
                     m_run <= m_run + 1;
                  end
               end else begin
                  m_run <= 0;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      chk("D", int'(D), int'(e_D));
      chk("loadn", int'(loadn), int'(e_loadn));
      chk("pgt_1hz", int'(pgt_1hz), int'(e_pgt));
      chk("invalid", int'(invalid), int'(e_inv));
      if (!loadn) lo_cnt++;
      if (invalid) inv_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int base_lo, base_inv, r, a, b, hold;
      resetn  = 1'b0;
      keypad  = '0;
      enablen = 1'b0;
      step(3);
      chk("rst_D", int'(D), 0);
      chk("rst_loadn", int'(loadn), 1);
      chk("rst_pgt", int'(pgt_1hz), 0);
      chk("rst_invalid", int'(invalid), 0);
      resetn = 1'b1;
      step(3);

      // Key 9 held 12 cycles: accept after edge 6, release 4 samples later.
      base_lo = lo_cnt;
      keypad = 10'b1000000000;
      step(5);
      chk("t2_loadn_e5", int'(loadn), 1);
      step(1);
      chk("t2_loadn_e6", int'(loadn), 0);
      chk("t2_D", int'(D), 9);
      chk("t2_pgt", int'(pgt_1hz), 1);
      step(6);
      keypad = '0;
      step(5);
      chk("t2_pgt_held", int'(pgt_1hz), 1);
      step(1);
      chk("t2_pgt_drop", int'(pgt_1hz), 0);
      chk("t2_pulses", lo_cnt - base_lo, 1);
      step(4);

      // Bounce on key 3.
      base_lo  = lo_cnt;
      base_inv = inv_cnt;
      keypad = 10'b0000001000;
      step(2);
      keypad = '0;
      step(1);
      keypad = 10'b0000001000;
      step(12);
      chk("t3_D", int'(D), 3);
      chk("t3_pulses", lo_cnt - base_lo, 1);
      chk("t3_invalid", inv_cnt - base_inv, 0);
      keypad = '0;
      step(8);

      // Two keys together.
      base_lo = lo_cnt;
      keypad = 10'b1000010000;
      step(3);
      chk("t4_invalid", int'(invalid), 1);
      chk("t4_D_hold", int'(D), 3);
      keypad = '0;
      step(4);
      keypad = 10'b0000000001;
      step(10);
      chk("t4_D", int'(D), 0);
      chk("t4_pulses", lo_cnt - base_lo, 1);
      keypad = '0;
      step(8);

      // Disabled, then enabled while held.
      base_lo = lo_cnt;
      enablen = 1'b1;
      keypad = 10'b0000001000;
      step(10);
      chk("t5_blocked", lo_cnt - base_lo, 0);
      enablen = 1'b0;
      step(3);
      chk("t5_loadn_e3", int'(loadn), 1);
      step(1);
      chk("t5_loadn_e4", int'(loadn), 0);
      chk("t5_D", int'(D), 3);
      keypad = '0;
      step(8);

      // Asynchronous reset while pressed.
      keypad = 10'b0010000000;
      step(8);
      chk("t6_D_pre", int'(D), 7);
      chk("t6_pgt_pre", int'(pgt_1hz), 1);
      #1;
      resetn = 1'b0;
      #1;
      chk("t6_D_async", int'(D), 0);
      chk("t6_pgt_async", int'(pgt_1hz), 0);
      step(2);
      resetn = 1'b1;
      step(5);
      chk("t6_loadn_e5", int'(loadn), 1);
      step(1);
      chk("t6_loadn_e6", int'(loadn), 0);
      chk("t6_D", int'(D), 7);
      keypad = '0;
      step(8);

      // Random bursts of idle, single and multiple keys.
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 3) begin
            keypad = '0;
         end else if (r < 8) begin
            keypad = NK'(1) << $urandom_range(0, NK-1);
         end else begin
            a = $urandom_range(0, NK-1);
            b = (a + $urandom_range(1, NK-1)) % NK;
            keypad = (NK'(1) << a) | (NK'(1) << b);
         end
         enablen = ($urandom_range(0, 5) == 0);
         hold = $urandom_range(1, 9);
         step(hold);
         if ($urandom_range(0, 60) == 0) begin
            #1;
            resetn = 1'b0;
            step(1);
            resetn = 1'b1;
         end
      end
      keypad = '0;
      enablen = 1'b0;
      step(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
